solver_sequencer: RTL and testbench

SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

---
 rtl/solver_sequencer_pkg.sv | 33 +++
 rtl/solver_sequencer_rom_mux.sv | 30 +++
 rtl/solver_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_solver_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solver_sequencer_pkg.sv
// Shared constants for the solver sequencer: FSM encoding, reset hold length,
// flattened-slice widths and small arithmetic helpers.
package solver_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SELECT     = 3'd1;
    localparam logic [2:0] ST_RESET_CORE = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_REPORT     = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    localparam int RESET_HOLD_CYCLES = 2;
    localparam int HOLD_CNT_W        = 2;
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_HOLD_CYCLES - 1);

    localparam int ROM_DATA_W = 8;
    localparam int PART_W     = 64;
    localparam int CNT_W      = 32;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Width of one per-core ROM address slice.
    function automatic int addr_w(input int n_addr_bits);
        return n_addr_bits + 1;
    endfunction

    // Cycle counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

endpackage

// File: rtl/solver_sequencer_rom_mux.sv
// Routes the active core's ROM address to the shared ROM and returns rom_valid
// only to that core; everything is zero while not running.
module seq_rom_mux
    import solver_sequencer_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ID_BITS = 2,
    parameter int ADDR_W  = 17
) (
    input  logic                      run,
    input  logic [ID_BITS-1:0]        sel,
    input  logic [N_CORES*ADDR_W-1:0] core_rom_addr,
    input  logic                      rom_valid,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [N_CORES-1:0]        core_rom_valid
);

    // One-hot select; at most one slice contributes to the OR.
    always_comb begin
        rom_addr       = '0;
        core_rom_valid = '0;
        for (int i = 0; i < N_CORES; i++) begin
            logic hit_s;
            hit_s             = run && (int'(sel) == i);
            rom_addr          = rom_addr | ({ADDR_W{hit_s}} & core_rom_addr[i*ADDR_W +: ADDR_W]);
            core_rom_valid[i] = hit_s & rom_valid;
        end
    end

endmodule

// File: rtl/solver_sequencer.sv
// Runs each enabled solver core in turn: reset it, let it stream the shared ROM,
// then hand its result (or a timeout marker) out through a valid/ready port.
module solver_sequencer
    import solver_sequencer_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int N_ADDR_BITS = 16,
    parameter int ID_BITS     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_CORES-1:0]                   core_enable,
    input  logic [CNT_W-1:0]                     timeout_limit,
    output logic [N_ADDR_BITS:0]                 rom_addr,
    input  logic [ROM_DATA_W-1:0]                rom_data,
    input  logic                                 rom_valid,
    output logic [N_CORES-1:0]                   core_rst,
    input  logic [N_CORES*(N_ADDR_BITS+1)-1:0]   core_rom_addr,
    output logic [ROM_DATA_W-1:0]                core_rom_data,
    output logic [N_CORES-1:0]                   core_rom_valid,
    input  logic [N_CORES-1:0]                   core_done,
    input  logic [N_CORES*PART_W-1:0]            core_part1,
    input  logic [N_CORES*PART_W-1:0]            core_part2,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [ID_BITS-1:0]                   res_core_id,
    output logic [PART_W-1:0]                    res_part1,
    output logic [PART_W-1:0]                    res_part2,
    output logic                                 res_timeout,
    output logic                                 busy,
    output logic                                 all_done
);

    localparam int ADDR_W = addr_w(N_ADDR_BITS);

    logic [2:0]            state_r,     state_nxt_s;
    logic [ID_BITS-1:0]    idx_r,       idx_nxt_s;
    logic [N_CORES-1:0]    enable_r,    enable_nxt_s;
    logic [CNT_W-1:0]      tlim_r,      tlim_nxt_s;
    logic [CNT_W-1:0]      cnt_r,       cnt_nxt_s;
    logic [HOLD_CNT_W-1:0] hold_r,      hold_nxt_s;
    logic                  res_valid_r, res_valid_nxt_s;
    logic                  res_to_r,    res_to_nxt_s;
    logic [ID_BITS-1:0]    res_id_r,    res_id_nxt_s;
    logic [PART_W-1:0]     res_p1_r,    res_p1_nxt_s;
    logic [PART_W-1:0]     res_p2_r,    res_p2_nxt_s;
    logic                  busy_r,      busy_nxt_s;
    logic                  all_done_r,  all_done_nxt_s;
    logic [N_CORES-1:0]    core_rst_r,  core_rst_nxt_s;

    logic                  enable_sel_s;
    logic                  done_sel_s;
    logic [PART_W-1:0]     part1_sel_s;
    logic [PART_W-1:0]     part2_sel_s;
    logic                  last_s;
    logic                  timeout_hit_s;

    // Per-core views of the active index, built as a one-hot OR to stay index-safe.
    always_comb begin
        enable_sel_s = 1'b0;
        done_sel_s   = 1'b0;
        part1_sel_s  = '0;
        part2_sel_s  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            logic hit_s;
            hit_s        = (int'(idx_r) == i);
            enable_sel_s = enable_sel_s | (hit_s & enable_r[i]);
            done_sel_s   = done_sel_s   | (hit_s & core_done[i]);
            part1_sel_s  = part1_sel_s  | ({PART_W{hit_s}} & core_part1[i*PART_W +: PART_W]);
            part2_sel_s  = part2_sel_s  | ({PART_W{hit_s}} & core_part2[i*PART_W +: PART_W]);
        end
    end

    assign last_s        = (int'(idx_r) == (N_CORES - 1));
    assign timeout_hit_s = (tlim_r != {CNT_W{1'b0}}) && (cnt_r == (tlim_r - CNT_ONE));

    // Sequencer next-state and payload capture.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        enable_nxt_s    = enable_r;
        tlim_nxt_s      = tlim_r;
        cnt_nxt_s       = cnt_r;
        hold_nxt_s      = hold_r;
        res_valid_nxt_s = res_valid_r;
        res_to_nxt_s    = res_to_r;
        res_id_nxt_s    = res_id_r;
        res_p1_nxt_s    = res_p1_r;
        res_p2_nxt_s    = res_p2_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s  = ST_SELECT;
                    enable_nxt_s = core_enable;
                    tlim_nxt_s   = timeout_limit;
                    idx_nxt_s    = '0;
                end else begin
                    state_nxt_s  = state_r;
                end
            end
            ST_SELECT: begin
                if (enable_sel_s) begin
                    state_nxt_s = ST_RESET_CORE;
                    hold_nxt_s  = '0;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    idx_nxt_s   = idx_r + ID_BITS'(1'b1);
                end
            end
            ST_RESET_CORE: begin
                if (hold_r == HOLD_LAST) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    hold_nxt_s  = hold_r + HOLD_CNT_W'(1'b1);
                end
            end
            ST_RUN: begin
                cnt_nxt_s = sat_inc(cnt_r);
                // A core finishing on its last allowed cycle still reports its result.
                if (done_sel_s) begin
                    state_nxt_s     = ST_REPORT;
                    res_valid_nxt_s = 1'b1;
                    res_to_nxt_s    = 1'b0;
                    res_id_nxt_s    = idx_r;
                    res_p1_nxt_s    = part1_sel_s;
                    res_p2_nxt_s    = part2_sel_s;
                end else if (timeout_hit_s) begin
                    state_nxt_s     = ST_REPORT;
                    res_valid_nxt_s = 1'b1;
                    res_to_nxt_s    = 1'b1;
                    res_id_nxt_s    = idx_r;
                    res_p1_nxt_s    = '0;
                    res_p2_nxt_s    = '0;
                end else begin
                    state_nxt_s     = ST_RUN;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    res_valid_nxt_s = 1'b0;
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SELECT;
                        idx_nxt_s   = idx_r + ID_BITS'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                res_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Status flags and core resets follow the next state so they line up with it.
    always_comb begin
        busy_nxt_s     = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
        all_done_nxt_s = (state_nxt_s == ST_DONE);
        core_rst_nxt_s = '1;
        for (int i = 0; i < N_CORES; i++) begin
            core_rst_nxt_s[i] = ~(((state_nxt_s == ST_RUN) || (state_nxt_s == ST_REPORT))
                                  && (int'(idx_nxt_s) == i));
        end
    end

    // State registers with synchronous reset; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            enable_r    <= '0;
            tlim_r      <= '0;
            cnt_r       <= '0;
            hold_r      <= '0;
            res_valid_r <= 1'b0;
            res_to_r    <= 1'b0;
            res_id_r    <= '0;
            res_p1_r    <= '0;
            res_p2_r    <= '0;
            busy_r      <= 1'b0;
            all_done_r  <= 1'b0;
            core_rst_r  <= '1;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            enable_r    <= enable_nxt_s;
            tlim_r      <= tlim_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hold_r      <= hold_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            res_to_r    <= res_to_nxt_s;
            res_id_r    <= res_id_nxt_s;
            res_p1_r    <= res_p1_nxt_s;
            res_p2_r    <= res_p2_nxt_s;
            busy_r      <= busy_nxt_s;
            all_done_r  <= all_done_nxt_s;
            core_rst_r  <= core_rst_nxt_s;
        end
    end

    seq_rom_mux #(
        .N_CORES (N_CORES),
        .ID_BITS (ID_BITS),
        .ADDR_W  (ADDR_W)
    ) u_rom_mux (
        .run            (state_r == ST_RUN),
        .sel            (idx_r),
        .core_rom_addr  (core_rom_addr),
        .rom_valid      (rom_valid),
        .rom_addr       (rom_addr),
        .core_rom_valid (core_rom_valid)
    );

    assign core_rom_data = rom_data;
    assign core_rst      = core_rst_r;
    assign res_valid     = res_valid_r;
    assign res_timeout   = res_to_r;
    assign res_core_id   = res_id_r;
    assign res_part1     = res_p1_r;
    assign res_part2     = res_p2_r;
    assign busy          = busy_r;
    assign all_done      = all_done_r;

endmodule

// File: tb/tb_solver_sequencer.sv
// Scoreboard bench for solver_sequencer with behavioural cores and a small ROM.
module tb_solver_sequencer;
    localparam int NC  = 4;
    localparam int NAB = 16;
    localparam int IDB = 2;
    localparam int AW  = NAB + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [NC-1:0]   core_enable = '0;
    logic [31:0]     timeout_limit = '0;
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data;
    logic            rom_valid;
    logic [NC-1:0]   core_rst;
    logic [NC*AW-1:0] core_rom_addr;
    logic [7:0]      core_rom_data;
    logic [NC-1:0]   core_rom_valid;
    logic [NC-1:0]   core_done;
    logic [NC*64-1:0] core_part1, core_part2;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [IDB-1:0]  res_core_id;
    logic [63:0]     res_part1, res_part2;
    logic            res_timeout, busy, all_done;

    localparam logic [63:0] P1 [NC] = '{64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
                                        64'hCAFE_F00D_1234_5678, 64'hFFFF_0000_FFFF_0000};
    localparam logic [63:0] P2 [NC] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                        64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};

    solver_sequencer #(.N_CORES(NC), .N_ADDR_BITS(NAB), .ID_BITS(IDB)) dut (
        .clk(clk), .rst(rst), .start(start), .core_enable(core_enable),
        .timeout_limit(timeout_limit), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_valid(rom_valid), .core_rst(core_rst), .core_rom_addr(core_rom_addr),
        .core_rom_data(core_rom_data), .core_rom_valid(core_rom_valid),
        .core_done(core_done), .core_part1(core_part1), .core_part2(core_part2),
        .res_valid(res_valid), .res_ready(res_ready), .res_core_id(res_core_id),
        .res_part1(res_part1), .res_part2(res_part2), .res_timeout(res_timeout),
        .busy(busy), .all_done(all_done)
    );

    always #5 clk = ~clk;

    // Behavioural cores: count cycles out of reset, done once the count hits dlim.
    int unsigned ccnt [NC];
    int unsigned dlim [NC];
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_rst[i]) ccnt[i] <= 0;
            else             ccnt[i] <= ccnt[i] + 1;
        end
    end
    always_comb begin
        core_rom_addr = '0;
        core_part1    = '0;
        core_part2    = '0;
        core_done     = '0;
        for (int i = 0; i < NC; i++) begin
            core_done[i]                = (ccnt[i] >= dlim[i]);
            core_rom_addr[i*AW +: AW]   = AW'(i * 64) + AW'(ccnt[i]);
            core_part1[i*64 +: 64]      = P1[i];
            core_part2[i*64 +: 64]      = P2[i];
        end
    end

    assign rom_valid = (rom_addr <= 17'd137);
    assign rom_data  = rom_addr[7:0] ^ 8'h5A;

    typedef struct packed {
        logic [IDB-1:0] id;
        logic [63:0]    p1;
        logic [63:0]    p2;
        logic           to;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int   run_cnt [NC];
    int   cv_hi [NC];
    int   cv_lo [NC];
    int   xfers = 0;
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    logic [63:0] pv1, pv2;
    logic [IDB-1:0] pid;
    logic pto;

    // Monitor: ROM routing every cycle, payload stability, and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            int   act;
            exp_t e;
            act = -1;
            for (int i = 0; i < NC; i++)
                if (!core_rst[i] && !res_valid && busy) act = i;
            if (act >= 0) begin
                run_cnt[act]++;
                chk("rom_addr_track", 64'(rom_addr), 64'(core_rom_addr[act*AW +: AW]));
                chk("core_rom_valid_route", 64'(core_rom_valid), 64'(NC'(rom_valid) << act));
                if (core_rom_valid[act]) cv_hi[act]++;
                else                     cv_lo[act]++;
            end else begin
                chk("rom_addr_idle", 64'(rom_addr), 64'd0);
                chk("core_rom_valid_idle", 64'(core_rom_valid), 64'd0);
            end
            chk("core_rom_data", 64'(core_rom_data), 64'(rom_addr[7:0] ^ 8'h5A));
            if (res_valid && prev_v && !prev_hs) begin
                chk("stable_part1", res_part1, pv1);
                chk("stable_part2", res_part2, pv2);
                chk("stable_id", 64'(res_core_id), 64'(pid));
                chk("stable_timeout", 64'(res_timeout), 64'(pto));
            end
            if (res_valid && res_ready) begin
                xfers++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id %0d expected none", res_core_id);
                end else begin
                    e = sbq.pop_front();
                    chk("res_core_id", 64'(res_core_id), 64'(e.id));
                    chk("res_part1", res_part1, e.p1);
                    chk("res_part2", res_part2, e.p2);
                    chk("res_timeout", 64'(res_timeout), 64'(e.to));
                end
            end
            prev_v  = res_valid;
            prev_hs = res_valid && res_ready;
            pv1 = res_part1;
            pv2 = res_part2;
            pid = res_core_id;
            pto = res_timeout;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NC; i++) begin
            run_cnt[i] = 0;
            cv_hi[i]   = 0;
            cv_lo[i]   = 0;
        end
        xfers = 0;
    endtask

    task automatic pulse_start(input logic [NC-1:0] en, input logic [31:0] tl);
        core_enable   = en;
        timeout_limit = tl;
        start         = 1'b1;
        tick(1);
        start         = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!all_done && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 64'(all_done), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        dlim = '{10, 32'hFFFF_FFFF, 20, 32'hFFFF_FFFF};
        clear_stats();
        rst = 1'b1;
        tick(3);
        chk("rst_core_rst", 64'(core_rst), 64'hF);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_part1", res_part1, 64'd0);
        chk("rst_part2", res_part2, 64'd0);
        chk("rst_id", 64'(res_core_id), 64'd0);
        chk("rst_timeout", 64'(res_timeout), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        rst = 1'b0;
        tick(2);

        // Cores 0 and 2 finish normally; results in index order.
        clear_stats();
        res_ready = 1'b1;
        sbq.push_back('{id: 2'd0, p1: P1[0], p2: P2[0], to: 1'b0});
        sbq.push_back('{id: 2'd2, p1: P1[2], p2: P2[2], to: 1'b0});
        pulse_start(4'b0101, 32'd0);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_all_done", 400);
        chk("t1_queue_empty", 64'(sbq.size()), 64'd0);
        chk("t1_xfers", 64'(xfers), 64'd2);
        chk("t1_run_cycles_c0", 64'(run_cnt[0]), 64'd11);
        chk("t1_run_cycles_c2", 64'(run_cnt[2]), 64'd21);
        chk("t1_run_cycles_c1", 64'(run_cnt[1]), 64'd0);
        chk("t1_c0_valid_hi", 64'(cv_hi[0]), 64'd11);
        chk("t1_c2_valid_toggle", 64'((cv_hi[2] == 10) && (cv_lo[2] == 11)), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // Core 1 never finishes: timeout after exactly 100 RUN cycles, ready held low.
        clear_stats();
        res_ready = 1'b0;
        sbq.push_back('{id: 2'd1, p1: 64'd0, p2: 64'd0, to: 1'b1});
        pulse_start(4'b0010, 32'd100);
        n = 0;
        while (!res_valid && n < 300) begin
            tick(1);
            n++;
        end
        chk("t2_valid_seen", 64'(res_valid), 64'd1);
        tick(10);
        core_enable = 4'hF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(39);
        chk("t2_valid_held", 64'(res_valid), 64'd1);
        chk("t2_busy_held", 64'(busy), 64'd1);
        chk("t2_no_xfer", 64'(xfers), 64'd0);
        chk("t2_core_rst_held", 64'(core_rst), 64'hD);
        res_ready = 1'b1;
        wait_done("t2_all_done", 20);
        chk("t2_xfers", 64'(xfers), 64'd1);
        chk("t2_queue_empty", 64'(sbq.size()), 64'd0);
        chk("t2_run_cycles_c1", 64'(run_cnt[1]), 64'd100);

        // Empty enable mask, started from DONE: walks every index, no result.
        clear_stats();
        pulse_start(4'b0000, 32'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        n = 1;
        while (!all_done && n < 20) begin
            tick(1);
            n++;
        end
        chk("t3_cycles_to_done", 64'(n), 64'(NC + 1));
        chk("t3_no_xfer", 64'(xfers), 64'd0);

        // Reset in the middle of core 2's run.
        clear_stats();
        dlim[2] = 32'hFFFF_FFFF;
        pulse_start(4'b0100, 32'd0);
        n = 0;
        while (core_rst[2] && n < 50) begin
            tick(1);
            n++;
        end
        chk("t4_core2_running", 64'(core_rst), 64'hB);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("t4_core_rst", 64'(core_rst), 64'hF);
        chk("t4_res_valid", 64'(res_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_all_done", 64'(all_done), 64'd0);
        chk("t4_rom_addr", 64'(rom_addr), 64'd0);
        chk("t4_core_rom_valid", 64'(core_rom_valid), 64'd0);
        rst = 1'b0;
        tick(5);
        chk("t4_post_res_valid", 64'(res_valid), 64'd0);
        chk("t4_post_busy", 64'(busy), 64'd0);
        chk("t4_post_all_done", 64'(all_done), 64'd0);
        chk("t4_no_xfer", 64'(xfers), 64'd0);
        chk("t4_queue_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
